// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU request link: op encodings, frame
// types, error-flag positions and receiver FSM states.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  localparam logic DATA_TYPE = 1'b0;
  localparam logic CMD_TYPE  = 1'b1;

  // Bit positions inside err = {data, crc, op}
  localparam int ERR_DATA = 2;
  localparam int ERR_CRC  = 1;
  localparam int ERR_OP   = 0;

  localparam logic [3:0] DATA_FRAMES  = 4'd8;
  localparam logic [3:0] DATA_CNT_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TYPE,
    ST_PAYLOAD,
    ST_STOP
  } rx_state_e;

  function automatic logic op_supported(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_crc4.sv
// Combinational CRC-4 (x^4 + x + 1, init 0) over a 68-bit word, MSB first.
// Shared between the receiver and the transmitter side of the link.
module alu_crc4 (
  input  logic [67:0] data_i,
  output logic [3:0]  crc_o
);

  logic [3:0] crc;

  always_comb begin
    crc = 4'h0;
    // NOTE: blocking assignments chain each loop iteration into the next, giving
    // one unrolled LFSR step per bit; non-blocking would keep only the last step.
    for (int i = 67; i >= 0; i--) begin
      logic fb;
      fb  = crc[3] ^ data_i[i];
      crc = {crc[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
    end
  end

  assign crc_o = crc;

endmodule

// File: rtl/alu_serial_rx.sv
// Serial ALU request receiver: deframes 11-bit frames, assembles 8 data bytes
// plus a cmd byte into one packet, checks it and holds the result for a consumer.
module alu_serial_rx
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  op,
  output logic [2:0]  err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow
);

  rx_state_e   state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        type_q, type_d;
  logic [3:0]  data_cnt_q, data_cnt_d;
  logic [63:0] ba_q, ba_d;

  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  err_q, err_d;
  logic        out_valid_q, out_valid_d;
  logic        overflow_q, overflow_d;

  logic        complete;
  logic [2:0]  pkt_err;
  logic [3:0]  crc_calc;

  alu_crc4 u_crc (
    .data_i ({ba_q, 1'b1, byte_q[6:4]}),
    .crc_o  (crc_calc)
  );

  always_comb begin
    // NOTE: every _d defaults to its _q before any branch, so no path through
    // this block can leave a variable unassigned and infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_d      = byte_q;
    type_d      = type_q;
    data_cnt_d  = data_cnt_q;
    ba_d        = ba_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    complete    = 1'b0;
    pkt_err     = 3'b000;

    unique case (state_q)
      ST_IDLE: begin
        if (!sin) begin
          state_d   = ST_TYPE;
          bit_cnt_d = 3'd0;
        end
      end
      ST_TYPE: begin
        type_d  = sin;
        state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        byte_d    = {byte_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = ST_STOP;
      end
      ST_STOP: begin
        state_d = ST_IDLE;
        if (!sin) begin
          // Framing error: drop the packet so far and report it as a data error.
          complete          = 1'b1;
          pkt_err[ERR_DATA] = 1'b1;
          data_cnt_d        = 4'd0;
          ba_d              = 64'd0;
        end else if (type_q == DATA_TYPE) begin
          ba_d = {ba_q[55:0], byte_q};
          if (data_cnt_q != DATA_CNT_MAX) data_cnt_d = data_cnt_q + 4'd1;
        end else if (type_q == CMD_TYPE) begin
          complete   = 1'b1;
          data_cnt_d = 4'd0;
          ba_d       = 64'd0;
          if (data_cnt_q != DATA_FRAMES)        pkt_err[ERR_DATA] = 1'b1;
          else if (crc_calc != byte_q[3:0])     pkt_err[ERR_CRC]  = 1'b1;
          else if (!op_supported(byte_q[6:4]))  pkt_err[ERR_OP]   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new packet always wins the output registers; losing an unread one is sticky.
    if (complete) begin
      a_d         = ba_q[31:0];
      b_d         = ba_q[63:32];
      op_d        = byte_q[6:4];
      err_d       = pkt_err;
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) overflow_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_q      <= 8'd0;
      type_q      <= DATA_TYPE;
      data_cnt_q  <= 4'd0;
      // NOTE: the 64-bit {B,A} register is reset as well, so a partial packet
      // interrupted by rst_n can never leak into a later result.
      ba_q        <= 64'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      op_q        <= 3'd0;
      err_q       <= 3'd0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_q      <= byte_d;
      type_q      <= type_d;
      data_cnt_q  <= data_cnt_d;
      ba_q        <= ba_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_serial_rx.sv
// Directed bench for alu_serial_rx: frames are bit-banged on sin and the
// captured packet results are compared against hand-derived values.
module tb_alu_serial_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sin;
  logic        out_ready;
  logic [31:0] a, b;
  logic [2:0]  op, err;
  logic        out_valid, overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_serial_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .a         (a),
    .b         (b),
    .op        (op),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  // Reference CRC by polynomial long division of {B,A,1,op}*x^4 by 10011.
  function automatic logic [3:0] crc_ref(input logic [31:0] bb, input logic [31:0] aa,
                                         input logic [2:0] o);
    logic [71:0] r;
    r = {bb, aa, 1'b1, o, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [7:0] cmd_of(input logic [31:0] bb, input logic [31:0] aa,
                                        input logic [2:0] o);
    return {1'b0, o, crc_ref(bb, aa, o)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    sin = v;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_body(input logic t, input logic [7:0] by);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(by[i]);
  endtask

  task automatic send_frame(input logic t, input logic [7:0] by, input logic stop);
    send_body(t, by);
    send_bit(stop);
  endtask

  // Sends n data frames in B[31:24]..B[7:0], A[31:24]..A[7:0] order, wrapping after 8.
  task automatic send_data(input logic [31:0] bb, input logic [31:0] aa, input int n);
    logic [63:0] ba;
    ba = {bb, aa};
    for (int i = 0; i < n; i++) send_frame(1'b0, 8'(ba >> (56 - 8 * (i % 8))), 1'b1);
  endtask

  task automatic send_packet(input logic [31:0] bb, input logic [31:0] aa, input int n,
                             input logic [7:0] cmd);
    send_data(bb, aa, n);
    send_frame(1'b1, cmd, 1'b1);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    send_bit(1'b1);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL accept_clear: out_valid=%b want 0", out_valid);
    end
  endtask

  // Compares valid/op/err of the current result in one go.
  task automatic expect_result(input string name, input logic [2:0] e_op, input logic [2:0] e_err);
    checks++;
    if ({out_valid, op, err} !== {1'b1, e_op, e_err}) begin
      errors++;
      $display("FAIL %s: valid/op/err=%b/%b/%b want 1/%b/%b", name, out_valid, op, err, e_op, e_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sin = 1'b1; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a, b, op, err, out_valid, overflow} !== 72'd0) begin
      errors++;
      $display("FAIL reset_outputs: a=%h b=%h op=%b err=%b v=%b ovf=%b want all 0",
               a, b, op, err, out_valid, overflow);
    end
    #2 rst_n = 1'b1;
    tick();
    idle(2);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_good_and();
    send_packet(32'h0, 32'h0, 8, 8'h0B);
    expect_result("and_zero", 3'b000, 3'b000);
    checks++;
    if ({a, b, overflow} !== 65'd0) begin
      errors++; $display("FAIL and_operands: a=%h b=%h ovf=%b want 0/0/0", a, b, overflow);
    end
    accept();
  endtask

  task automatic test_crc();
    send_packet(32'h0, 32'h0, 8, 8'h47);
    expect_result("add_good_crc", 3'b100, 3'b000);
    accept();
    send_packet(32'h0, 32'h0, 8, 8'h46);
    expect_result("add_bad_crc", 3'b100, 3'b010);
    accept();
  endtask

  task automatic test_bad_op();
    send_packet(32'h0, 32'h0, 8, 8'h2D);
    expect_result("bad_op", 3'b010, 3'b001);
    accept();
  endtask

  task automatic test_data_count();
    send_packet(32'h0, 32'h0, 7, 8'h0B);
    expect_result("seven_frames", 3'b000, 3'b100);
    accept();
    send_packet(32'h0, 32'h0, 9, 8'h0B);
    expect_result("nine_frames", 3'b000, 3'b100);
    accept();
    send_packet(32'h0, 32'h0, 8, 8'h0B);
    expect_result("count_recovered", 3'b000, 3'b000);
    accept();
  endtask

  task automatic test_abort();
    send_data(32'h0, 32'h0, 3);
    send_frame(1'b0, 8'h55, 1'b0);
    checks++;
    if ({out_valid, err} !== 4'b1_100) begin
      errors++; $display("FAIL stop_abort: valid/err=%b/%b want 1/100", out_valid, err);
    end
    accept();
    send_packet(32'h0, 32'h0, 8, 8'h0B);
    expect_result("after_abort", 3'b000, 3'b000);
    accept();
  endtask

  task automatic test_operands();
    send_packet(32'hCAFE_F00D, 32'h1234_5678, 8, cmd_of(32'hCAFE_F00D, 32'h1234_5678, 3'b101));
    expect_result("sub_operands", 3'b101, 3'b000);
    checks++;
    if ({a, b} !== {32'h1234_5678, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL sub_ab: a=%h b=%h want 12345678 cafef00d", a, b);
    end
    accept();
    send_packet(32'h0000_00FF, 32'h8000_0001, 8, cmd_of(32'h0000_00FF, 32'h8000_0001, 3'b001));
    expect_result("or_operands", 3'b001, 3'b000);
    checks++;
    if ({a, b} !== {32'h8000_0001, 32'h0000_00FF}) begin
      errors++; $display("FAIL or_ab: a=%h b=%h want 80000001 000000ff", a, b);
    end
    accept();
  endtask

  task automatic test_same_edge();
    send_packet(32'h0, 32'h0, 8, 8'h0B);
    send_data(32'h0BAD_BEEF, 32'h0000_0042, 8);
    send_body(1'b1, cmd_of(32'h0BAD_BEEF, 32'h0000_0042, 3'b100));
    out_ready = 1'b1;
    send_bit(1'b1);
    checks++;
    if ({out_valid, a, b, overflow} !== {1'b1, 32'h0000_0042, 32'h0BAD_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL same_edge: v=%b a=%h b=%h ovf=%b want 1 00000042 0badbeef 0",
               out_valid, a, b, overflow);
    end
    send_bit(1'b1);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL same_edge_drop: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_pulse();
    out_ready = 1'b1;
    send_data(32'h0, 32'h0, 8);
    send_body(1'b1, 8'h47);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL pulse_before_stop: out_valid=%b want 0", out_valid);
    end
    send_bit(1'b1);
    expect_result("pulse_latency", 3'b100, 3'b000);
    send_bit(1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL pulse_width: out_valid=%b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int seen;
    send_packet(32'h1111_2222, 32'h3333_4444, 8, cmd_of(32'h1111_2222, 32'h3333_4444, 3'b000));
    send_packet(32'h5555_6666, 32'h7777_8888, 8, cmd_of(32'h5555_6666, 32'h7777_8888, 3'b100));
    expect_result("b2b_second", 3'b100, 3'b000);
    checks++;
    if ({a, b, overflow} !== {32'h7777_8888, 32'h5555_6666, 1'b1}) begin
      errors++;
      $display("FAIL b2b_overflow: a=%h b=%h ovf=%b want 77778888 55556666 1", a, b, overflow);
    end
    accept();
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_sticky: overflow=%b want 1", overflow);
    end
    // Third packet, interrupted by reset partway through a frame.
    send_data(32'h1111_2222, 32'h3333_4444, 3);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a, b, op, err, out_valid, overflow} !== 72'd0) begin
      errors++;
      $display("FAIL midpkt_reset: a=%h b=%h op=%b err=%b v=%b ovf=%b want all 0",
               a, b, op, err, out_valid, overflow);
    end
    sin = 1'b1;
    #10 rst_n = 1'b1;
    tick();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      send_bit(1'b1);
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL no_valid_after_reset: valid cycles=%0d ovf=%b want 0/0", seen, overflow);
    end
    send_packet(32'h0, 32'h0, 8, 8'h0B);
    expect_result("post_reset_packet", 3'b000, 3'b000);
    accept();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_good_and();
    test_crc();
    test_bad_op();
    test_data_count();
    test_abort();
    test_operands();
    test_same_edge();
    test_pulse();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_serial_rx.md
ALU_SERIAL_RX -- requirements
Module: alu_serial_rx

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  clock; all sampling on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sin  input  1  serial request line, one bit per clk, idle high.
REQ-005 a  output  32  operand A of accepted packet.
REQ-006 b  output  32  operand B of accepted packet.
REQ-007 op  output  3  operation field of accepted packet.
REQ-008 err  output  3  error flags {data, crc, op}; all zero = good packet.
REQ-009 out_valid  output  1  packet result (a, b, op, err) available.
REQ-010 out_ready  input  1  consumer accepts the result when high with out_valid.
REQ-011 overflow  output  1  sticky; a packet completed while out_valid was still pending.

Function
REQ-012 Frame format SHALL be 11 bits: start(0), type (0 data, 1 cmd), 8 payload bits MSB first, stop(1).
REQ-013 Packet SHALL be 8 data frames (B[31:24], B[23:16], B[15:8], B[7:0], then A in the same byte order) followed by 1 cmd frame {1'b0, op[2:0], crc[3:0]}.
REQ-014 FSM states SHALL be IDLE, TYPE, PAYLOAD, STOP; IDLE->TYPE on sampled sin=0; TYPE->PAYLOAD; PAYLOAD->STOP after 8 bits (3-bit counter); STOP->IDLE.
REQ-015 Data payloads SHALL shift into a 64-bit {B,A} register; a 4-bit data-frame counter SHALL saturate at 9.
REQ-016 Stop bit sampled 0 SHALL abort the packet: the data counter is cleared and the error packet {data} is issued.
REQ-017 Completed cmd frame with data counter != 8 SHALL yield err = 3'b100.
REQ-018 Otherwise, crc field != CRC4(x^4+x+1, init 0) over the 68-bit word {B, A, 1'b1, op} SHALL yield err = 3'b010.
REQ-019 Otherwise, op not in {AND 000, OR 001, ADD 100, SUB 101} SHALL yield err = 3'b001.
REQ-020 Error priority SHALL be data > crc > op; exactly one err bit is set per packet.
REQ-021 out_valid SHALL rise in the cycle after the posedge that samples the cmd stop bit; a, b, op, err are stable while out_valid=1.
REQ-022 out_valid SHALL stay high until a posedge with out_ready=1, then drop unless a new packet completes on that same edge.
REQ-023 A completion while out_valid=1 and out_ready=0 SHALL overwrite the output registers and set overflow.
REQ-024 Completion and acceptance on the same edge SHALL load the new packet with no overflow.
REQ-025 After each cmd frame the data counter and the {B,A} register SHALL clear; reception of the next start bit is allowed immediately after the stop bit.
REQ-026 Data frames beyond 8 SHALL keep shifting; the count of 9 marks the data error.

Reset
REQ-027 rst_n low SHALL force IDLE, clear all counters and shift registers, and set a=0, b=0, op=0, err=0, out_valid=0, overflow=0.
REQ-028 Reset mid-frame or mid-packet SHALL discard partial data; no out_valid is generated for it.
REQ-029 overflow SHALL clear only on reset.

Structure
REQ-030 Shared package alu_pkg SHALL hold the op encodings, frame-type constants DATA_TYPE=0 and CMD_TYPE=1, and the err bit positions.
REQ-031 CRC SHALL be a separate combinational sub-module alu_crc4 (68-bit data in, 4-bit crc out); it is reusable by the transmitter side.

Verification
REQ-032 Send A=0, B=0, op=AND with cmd byte 0x0B -> out_valid, a=0, b=0, op=000, err=000.
REQ-033 Send A=0, B=0, op=ADD with cmd byte 0x47 -> err=000, op=100; then cmd byte 0x46 -> err=010.
REQ-034 Send A=0, B=0 with cmd byte 0x2D (op=010, crc valid) -> err=001.
REQ-035 Send 7 data frames then cmd 0x0B -> err=100; then send 9 data frames then cmd -> err=100.
REQ-036 Send two good packets back-to-back with out_ready=0 -> second result visible, overflow=1; assert rst_n low mid-third packet -> all outputs 0, no out_valid.
REQ-037 Hold out_ready=1 while a packet completes -> out_valid is a one-cycle pulse, and latency is 1 cycle after the cmd stop bit.
